// File: rtl/htif_mailbox.sv
// HTIF tohost/fromhost mailbox: decodes core stores to tohost into halt, console and
// host-forwarded commands. Define HTIF_CONSOLE_EN to compile in the console byte path.
module htif_mailbox #(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR   = 'h7F8,
  parameter logic [XLEN-1:0] FROMHOST_ADDR = 'h800
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd_o,
  output logic            stall_o,
  output logic            cmd_valid_o,
  output logic [XLEN-1:0] cmd_data_o,
  input  logic            cmd_ready_i,
  input  logic            fh_valid_i,
  input  logic [XLEN-1:0] fh_data_i,
  output logic            halt_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic [XLEN-2:0] exit_code_o,
  output logic            char_valid_o,
  output logic [7:0]      char_o
);

  typedef enum logic [2:0] {IDLE, DECODE, FWD, CONS, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] tohost_q, fromhost_q;
  logic            tohost_load, tohost_clear, halt_enter;

  logic sel_to, sel_fh, to_store;
  logic [7:0] dev;

  assign sel_to   = (a_i == TOHOST_ADDR);
  assign sel_fh   = (a_i == FROMHOST_ADDR);
  assign to_store = we_i && sel_to;
  assign dev      = tohost_q[XLEN-1 -: 8];

`ifdef HTIF_CONSOLE_EN
  logic [7:0] cmd;
  assign cmd = tohost_q[XLEN-9 -: 8];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    tohost_load  = 1'b0;
    tohost_clear = 1'b0;
    halt_enter   = 1'b0;
    stall_o      = 1'b0;
    cmd_valid_o  = 1'b0;
    cmd_data_o   = '0;
    char_valid_o = 1'b0;
    char_o       = '0;
    unique case (state_q)
      IDLE: begin
        if (to_store) begin
          tohost_load = 1'b1;
          if (wd_i != '0) state_d = DECODE;
        end
      end
      DECODE: begin
        stall_o = to_store;
        if (dev == 8'd0 && tohost_q[0]) begin
          state_d    = HALT;
          halt_enter = 1'b1;
        end
`ifdef HTIF_CONSOLE_EN
        else if (dev == 8'd1 && cmd == 8'd1) state_d = CONS;
`endif
        else state_d = FWD;
      end
      FWD: begin
        stall_o     = to_store;
        cmd_valid_o = 1'b1;
        cmd_data_o  = tohost_q;
        if (cmd_ready_i) begin
          tohost_clear = 1'b1;
          state_d      = IDLE;
        end
      end
      CONS: begin
        stall_o = to_store;
`ifdef HTIF_CONSOLE_EN
        char_valid_o = 1'b1;
        char_o       = tohost_q[7:0];
`endif
        tohost_clear = 1'b1;
        state_d      = IDLE;
      end
      HALT: ;  // terminal: stores are silently dropped, no stall
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tohost_q <= '0;
    end else if (tohost_load) begin
      tohost_q <= wd_i;
    end else if (tohost_clear) begin
      tohost_q <= '0;
    end
  end

  // Host write has priority over a same-cycle core store.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fromhost_q <= '0;
    end else if (fh_valid_i) begin
      fromhost_q <= fh_data_i;
    end else if (we_i && sel_fh) begin
      fromhost_q <= wd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      exit_code_o <= '0;
    end else if (halt_enter) begin
      halt_o      <= 1'b1;
      exit_code_o <= tohost_q[XLEN-1:1];
      pass_o      <= (tohost_q[XLEN-1:1] == '0);
      fail_o      <= (tohost_q[XLEN-1:1] != '0);
    end
  end

  always_comb begin
    rd_o = '0;
    if (re_i) begin
      if (sel_to)      rd_o = tohost_q;
      else if (sel_fh) rd_o = fromhost_q;
    end
  end

endmodule

// File: doc/htif_mailbox.md
HTIF_MAILBOX -- requirements
Module: htif_mailbox

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width.
REQ-002 SHALL have parameter TOHOST_ADDR, default 'h7F8, byte address of the tohost register.
REQ-003 SHALL have parameter FROMHOST_ADDR, default 'h800, byte address of the fromhost register.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports we_i in 1 (core store), re_i in 1 (core load), a_i in XLEN (byte address), wd_i in XLEN (store data).
REQ-007 SHALL have ports rd_o out XLEN (load data) and stall_o out 1 (core must hold the current store).
REQ-008 SHALL have ports cmd_valid_o out 1, cmd_data_o out XLEN, cmd_ready_i in 1 (command to host).
REQ-009 SHALL have ports fh_valid_i in 1, fh_data_i in XLEN (host writes fromhost).
REQ-010 SHALL have ports halt_o out 1, pass_o out 1, fail_o out 1, exit_code_o out XLEN-1.
REQ-011 SHALL have ports char_valid_o out 1, char_o out 8 (console byte).

Function
REQ-012 Decode SHALL be full-word: a_i==TOHOST_ADDR selects tohost, a_i==FROMHOST_ADDR selects fromhost; all other addresses are ignored and read as 0.
REQ-013 rd_o SHALL be combinational: the selected register when re_i=1, else 0.
REQ-014 FSM states SHALL be IDLE, DECODE, FWD, CONS, HALT.
REQ-015 IDLE: a store to tohost with a nonzero value SHALL load tohost on the edge and move to DECODE; a store of 0 SHALL load tohost and stay in IDLE.
REQ-016 DECODE (1 cycle) SHALL use dev=tohost[XLEN-1:XLEN-8], cmd=tohost[XLEN-9:XLEN-16]:
  - dev==0 and tohost[0]==1 -> HALT
  - dev==1 and cmd==1 -> CONS
  - otherwise -> FWD
REQ-017 HALT entry SHALL latch exit_code_o=tohost>>1 and set halt_o=1; pass_o=1 if the code is 0, else fail_o=1. HALT SHALL be terminal until reset.
REQ-018 CONS SHALL drive char_valid_o=1 and char_o=tohost[7:0] for exactly one cycle, then clear tohost and return to IDLE.
REQ-019 FWD SHALL hold cmd_valid_o=1 with cmd_data_o=tohost stable until cmd_ready_i=1. On the handshake edge it SHALL clear tohost and return to IDLE.
REQ-020 A store to tohost in any state other than IDLE SHALL assert stall_o combinationally and SHALL NOT modify tohost. Exception: in HALT, stall_o=0 and the store is dropped.
REQ-021 stall_o SHALL be 0 for every other access.
REQ-022 fh_valid_i=1 SHALL load fromhost with fh_data_i. A core store to fromhost SHALL load wd_i.
REQ-023 If both REQ-022 fromhost writes occur in the same cycle, the host write SHALL win.
REQ-024 Latency from a tohost store edge: char_valid_o is high in cycle +2; cmd_valid_o is first high in cycle +2; halt_o is high from cycle +2.

Reset
REQ-025 rst_ni=0 SHALL asynchronously force:
  - state=IDLE, tohost=0, fromhost=0, exit_code_o=0
  - halt_o, pass_o, fail_o, cmd_valid_o, char_valid_o, stall_o = 0
  - char_o=0, cmd_data_o=0
REQ-026 Reset asserted in FWD SHALL drop cmd_valid_o immediately and discard the command.
REQ-027 The first store SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-028 Macro HTIF_CONSOLE_EN SHALL compile in the console path: the CONS state and the char_valid_o/char_o drive.
REQ-029 Without HTIF_CONSOLE_EN, dev==1/cmd==1 SHALL go to FWD, and char_valid_o and char_o SHALL be tied to 0.

Verification
REQ-030 Store 'h1 to 'h7F8 -> halt_o=1, pass_o=1, fail_o=0, exit_code_o=0 at edge +2. A later store 'h5 -> dropped, stall_o=0.
REQ-031 Store 'h7 to 'h7F8 -> fail_o=1, exit_code_o=3.
REQ-032 Store 'h0101_0000_0000_0041 to tohost (HTIF_CONSOLE_EN defined) -> char_valid_o pulses once with char_o='h41. tohost then reads 0.
REQ-033 Store 'h0200_0000_0000_0010 to tohost with cmd_ready_i low for 3 cycles -> cmd_valid_o held 3+ cycles with stable data. A second tohost store during the wait -> stall_o=1 and tohost unchanged.
REQ-034 Same-cycle fh_valid_i (data 'hAA) and core store of 'h55 to 'h800 -> fromhost reads 'hAA.
REQ-035 rst_ni pulsed low mid-FWD -> cmd_valid_o=0 immediately and all outputs at reset values.
